// File: rtl/vai_tx_sched_if.sv
// Request/upstream bundle between the sub-AFU Tx stages, the scheduler and the
// upstream CCI-P port. The master modport is the scheduler's view.
interface vai_tx_sched_if #(
    parameter int NUM_SUB_AFUS = 9,
    parameter int PAYLOAD_W    = 64,
    parameter int ID_W         = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1
);
    logic [NUM_SUB_AFUS-1:0]           afu_req_valid;
    logic [NUM_SUB_AFUS*PAYLOAD_W-1:0] afu_req_payload;
    logic [NUM_SUB_AFUS-1:0]           afu_req_ready;
    logic                              up_almFull;
    logic                              out_valid;
    logic [PAYLOAD_W-1:0]              out_payload;
    logic [ID_W-1:0]                   out_afu_id;

    modport master (
        input  afu_req_valid, afu_req_payload, up_almFull,
        output afu_req_ready, out_valid, out_payload, out_afu_id
    );

    modport slave (
        output afu_req_valid, afu_req_payload, up_almFull,
        input  afu_req_ready, out_valid, out_payload, out_afu_id
    );
endinterface

// File: rtl/vai_tx_sched.sv
// Round-robin Tx request scheduler with per-AFU outstanding quota and halt masking.
// Optional grant/stall statistics are built when VAI_TX_SCHED_STATS_EN is defined.
module vai_tx_sched #(
    parameter int NUM_SUB_AFUS    = 9,
    parameter int PAYLOAD_W       = 64,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ID_W            = (NUM_SUB_AFUS > 1) ? $clog2(NUM_SUB_AFUS) : 1
) (
    input  logic                    pClk,
    input  logic                    SoftReset,
    vai_tx_sched_if.master          bus,
    input  logic [NUM_SUB_AFUS-1:0] afu_halt,
    input  logic                    rsp_valid,
    input  logic [ID_W-1:0]         rsp_afu_id,
    output logic                    quota_err,
    input  logic [ID_W-1:0]         stat_sel,
    output logic [31:0]             stat_cnt
);
    localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_SUB_AFUS);
    localparam logic [7:0]    MAX_W = 8'(MAX_OUTSTANDING);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [7:0]           cnt_q [NUM_SUB_AFUS];
    logic [7:0]           cnt_d [NUM_SUB_AFUS];
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic [ID_W-1:0]      out_afu_id_q, out_afu_id_d;
    logic                 quota_err_q, quota_err_d;

    logic [NUM_SUB_AFUS-1:0]   elig;
    logic [NUM_SUB_AFUS-1:0]   gnt;
    logic [2*NUM_SUB_AFUS-1:0] rot;
    logic                      gnt_any;
    logic [ID_W:0]             gnt_sum;
    logic [ID_W-1:0]           gnt_id;
    logic [PAYLOAD_W-1:0]      gnt_payload;
    logic                      rsp_hit;

    // Rotate eligibility so bit k is AFU (ptr+k) mod N; the lowest set bit wins.
    always_comb begin
        elig    = '0;
        gnt_any = 1'b0;
        gnt_sum = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            elig[i] = bus.afu_req_valid[i] & ~afu_halt[i] & (cnt_q[i] < MAX_W) &
                      ~bus.up_almFull & ~SoftReset;
        end
        rot = {elig, elig} >> ptr_q;
        for (int k = 0; k < NUM_SUB_AFUS; k++) begin
            if (!gnt_any && rot[k]) begin
                gnt_any = 1'b1;
                gnt_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            end
        end
        if (gnt_sum >= NUM_W) begin
            gnt_sum = gnt_sum - NUM_W;
        end
        gnt_id = gnt_sum[ID_W-1:0];
        gnt    = gnt_any ? (NUM_SUB_AFUS'(1) << gnt_id) : '0;
        gnt_payload = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            if (gnt[i]) begin
                gnt_payload = bus.afu_req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        out_valid_d   = gnt_any;
        out_payload_d = out_payload_q;
        out_afu_id_d  = out_afu_id_q;
        quota_err_d   = quota_err_q;
        rsp_hit       = 1'b0;
        if (gnt_any) begin
            out_payload_d = gnt_payload;
            out_afu_id_d  = gnt_id;
            ptr_d = (gnt_id == ID_W'(NUM_SUB_AFUS-1)) ? '0 : gnt_id + ID_W'(1);
        end
        // A same-cycle grant and retire cancel out; retiring from zero is an error.
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            rsp_hit  = rsp_valid && (rsp_afu_id == ID_W'(i));
            cnt_d[i] = cnt_q[i];
            if (afu_halt[i]) begin
                cnt_d[i] = '0;
            end else begin
                if (rsp_hit && cnt_q[i] == 8'd0) begin
                    quota_err_d = 1'b1;
                end
                cnt_d[i] = cnt_q[i] + {7'd0, gnt[i]} - {7'd0, rsp_hit && cnt_q[i] != 8'd0};
            end
        end
        if (rsp_valid && ({1'b0, rsp_afu_id} >= NUM_W)) begin
            quota_err_d = 1'b1;
        end
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            ptr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_afu_id_q  <= '0;
            quota_err_q   <= 1'b0;
            for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= '0;
        end else begin
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_afu_id_q  <= out_afu_id_d;
            quota_err_q   <= quota_err_d;
            for (int i = 0; i < NUM_SUB_AFUS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.afu_req_ready = gnt;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_payload   = out_payload_q;
    assign bus.out_afu_id    = out_afu_id_q;
    assign quota_err         = quota_err_q;

`ifdef VAI_TX_SCHED_STATS_EN
    // A power-of-two AFU count has no spare select code, so the stall counter shadows the last AFU.
    localparam bit POW2      = (NUM_SUB_AFUS & (NUM_SUB_AFUS - 1)) == 0;
    localparam int STALL_IDX = POW2 ? NUM_SUB_AFUS - 1 : NUM_SUB_AFUS;

    logic [31:0] gcnt_q [NUM_SUB_AFUS];
    logic [31:0] gcnt_d [NUM_SUB_AFUS];
    logic [31:0] stall_q, stall_d;
    logic [31:0] stat_cnt_q, stat_cnt_d;

    always_comb begin
        stall_d    = stall_q + {31'd0, (|(bus.afu_req_valid & ~afu_halt)) & ~gnt_any};
        stat_cnt_d = '0;
        for (int i = 0; i < NUM_SUB_AFUS; i++) begin
            gcnt_d[i] = gcnt_q[i] + {31'd0, gnt[i]};
            if (stat_sel == ID_W'(i)) stat_cnt_d = gcnt_q[i];
        end
        if (stat_sel == ID_W'(STALL_IDX)) stat_cnt_d = stall_q;
    end

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            stall_q    <= '0;
            stat_cnt_q <= '0;
            for (int i = 0; i < NUM_SUB_AFUS; i++) gcnt_q[i] <= '0;
        end else begin
            stall_q    <= stall_d;
            stat_cnt_q <= stat_cnt_d;
            for (int i = 0; i < NUM_SUB_AFUS; i++) gcnt_q[i] <= gcnt_d[i];
        end
    end

    assign stat_cnt = stat_cnt_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif
endmodule

// File: doc/vai_tx_sched.md
Name: vai_tx_sched

Overview:
- Round-robin Tx request scheduler that shares one upstream CCI-P request channel between NUM_SUB_AFUS sub-AFU requesters.
- Sits between the per-AFU Tx audit stage and the manager upstream port.
- Enforces upstream almost-full back-pressure and a per-AFU outstanding-request quota.
- Retires quota on responses and drops/masks sub-AFUs held in reset by the manager.

Parameters:
NUM_SUB_AFUS, 9, number of requesters
PAYLOAD_W, 64, opaque request payload width (header+data packed by caller)
MAX_OUTSTANDING, 32, per-AFU in-flight request limit (1..255)
ID_W, $clog2(NUM_SUB_AFUS), requester index width (derived, not overridden)

Ports:
pClk  in  1  clock; all logic on posedge
SoftReset  in  1  synchronous active-high reset
up_almFull  in  1  upstream channel almost-full
afu_req_valid  in  NUM_SUB_AFUS  per-AFU request valid
afu_req_payload  in  NUM_SUB_AFUS*PAYLOAD_W  per-AFU payload, AFU i at [i*PAYLOAD_W +: PAYLOAD_W]
afu_req_ready  out  NUM_SUB_AFUS  one-hot grant; transfer when valid&ready
afu_halt  in  NUM_SUB_AFUS  sub-AFU held in reset by manager
rsp_valid  in  1  one response retired this cycle
rsp_afu_id  in  ID_W  owner of retired response
out_valid  out  1  registered request to upstream
out_payload  out  PAYLOAD_W  registered payload
out_afu_id  out  ID_W  source AFU of out_payload
quota_err  out  1  sticky: response with zero outstanding or invalid id
stat_sel  in  ID_W  statistics select (used only with feature)
stat_cnt  out  32  statistics readback

Behaviour:
- Reset values:
  - out_valid=0, out_payload=0, out_afu_id=0, afu_req_ready=0 (combinational, forced 0 while SoftReset), quota_err=0, stat_cnt=0.
  - RR pointer=0; all outstanding counters=0.
- Eligibility of AFU i: afu_req_valid[i] & ~afu_halt[i] & cnt[i]<MAX_OUTSTANDING & ~up_almFull.
- Arbitration is combinational from registered state:
  - Search starts at the pointer, ascending, wrapping NUM_SUB_AFUS-1 -> 0.
  - The first eligible AFU gets ready; at most one ready bit high per cycle.
- On grant to i: next cycle out_valid=1, out_payload=payload[i], out_afu_id=i (latency 1); pointer <= i+1 (wrap to 0).
- No grant: out_valid=0 next cycle; pointer unchanged.
- up_almFull=1 blocks all grants that cycle. A request already registered in out_valid still issues (upstream tolerates the almost-full slack).
- Counter rules for cnt[i] (8 bit):
  - +1 on grant to i.
  - -1 on rsp_valid with rsp_afu_id==i.
  - Both in the same cycle: unchanged.
- Response to an AFU with cnt=0, or rsp_afu_id>=NUM_SUB_AFUS: counter unchanged (saturating), quota_err set until SoftReset.
- afu_halt[i]=1: cnt[i] forced to 0 each cycle, responses for i ignored (no quota_err), never granted. Deassertion resumes normally.
- Requesters must hold payload stable while valid & ~ready. The scheduler does not buffer beyond the single output register.
- SoftReset mid-operation: a pending out_valid is dropped next cycle; all counters and the pointer clear.

Optional Feature:
- Macro VAI_TX_SCHED_STATS_EN.
- Defined:
  - Per-AFU 32-bit grant counters (wrap at 2^32-1 -> 0) plus one 32-bit stall counter.
  - The stall counter increments on cycles with any valid & ~halt request but no grant.
  - stat_cnt registered, 1-cycle latency: grant counter of stat_sel. stat_sel==NUM_SUB_AFUS-1 returns the stall counter when NUM_SUB_AFUS is a power of two; otherwise the stall counter is at index NUM_SUB_AFUS.
  - All counters clear on SoftReset.
- Undefined: counters absent; stat_cnt tied 0.

Test Plan:
- All 9 valid, no halt, almFull=0, pointer 0 -> grants 0,1,...,8,0 on consecutive cycles; out_afu_id follows one cycle later.
- Only AFU 3 valid, rsp never returned, MAX_OUTSTANDING=32 -> exactly 32 grants, then ready[3]=0. One rsp_valid with id 3 -> exactly one more grant.
- up_almFull=1 for 5 cycles with AFUs 2,5 valid -> no ready for 5 cycles, out_valid drops after 1. On release -> grant continues from the saved pointer.
- Grant to AFU 4 and rsp for AFU 4 in the same cycle with cnt[4]=7 -> cnt[4] stays 7. Rsp for AFU 6 with cnt=0 -> quota_err=1, sticky.
- afu_halt[1]=1 with cnt[1]=10 and valid -> never granted, cnt cleared. Rsp for id 1 -> no quota_err. Release -> granted in normal turn.
- With VAI_TX_SCHED_STATS_EN: 100 grants to AFU 0, stat_sel=0 -> stat_cnt=100 one cycle later. SoftReset -> 0.
